line_draw_arbiter: RTL

- Shares one line_drawer datapath among NUM_REQ requesters (e.g. animators, UI overlay, clear engine).
- Round-robin grant; latches the winner's endpoints and colour, sequences drawer reset, streams pixels to the framebuffer write port, and acks completion.
- Sits between the line-producing FSMs and the single line_drawer / framebuffer write interface.

---
 rtl/line_draw_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/line_draw_arbiter.sv
// Round-robin arbiter sharing one line_drawer among NUM_REQ line producers.
// Optional DRAW-state watchdog enabled by defining LINE_ARB_WATCHDOG_EN.
//
// state | meaning
// IDLE  | drawer held in reset, arbitrating requests
// START | one-cycle drawer reset so it loads the latched endpoints
// DRAW  | streaming drawer pixels to the framebuffer
// DONE  | ack pulse to the granted requester
module line_draw_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int CW          = 11,
    parameter int WDOG_CYCLES = 4095
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*CW-1:0] req_x0,
    input  logic [NUM_REQ*CW-1:0] req_y0,
    input  logic [NUM_REQ*CW-1:0] req_x1,
    input  logic [NUM_REQ*CW-1:0] req_y1,
    input  logic [NUM_REQ-1:0]    req_color,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  busy,
    output logic                  drawer_reset,
    output logic [CW-1:0]         drawer_x0,
    output logic [CW-1:0]         drawer_y0,
    output logic [CW-1:0]         drawer_x1,
    output logic [CW-1:0]         drawer_y1,
    input  logic [CW-1:0]         drawer_x,
    input  logic [CW-1:0]         drawer_y,
    output logic [CW-1:0]         pix_x,
    output logic [CW-1:0]         pix_y,
    output logic                  pix_color,
    output logic                  pix_valid,
    output logic                  err
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, DRAW, DONE} state_t;

    state_t               state_q;
    logic [GW-1:0]        rr_q;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        win_d;
    logic [GW-1:0]        cand;
    logic [CW-1:0]        x0_q;
    logic [CW-1:0]        y0_q;
    logic [CW-1:0]        x1_q;
    logic [CW-1:0]        y1_q;
    logic                 color_q;
    logic                 busy_q;
    logic                 drawer_reset_q;
    logic                 pix_valid_q;
    logic                 err_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 at_end;
    logic                 wdog_hit;

    // Scan downward so the candidate closest after rr_q is written last and wins.
    always_comb begin
        win_d = rr_q;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GW'((32'(rr_q) + 32'(k)) % 32'(NUM_REQ));
            if (req[cand]) begin
                win_d = cand;
            end
        end
    end

    assign at_end = (drawer_x == x1_q) && (drawer_y == y1_q);

`ifdef LINE_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else if (state_q != DRAW) begin
            wdog_q <= '0;
        end else if (!wdog_hit) begin
            wdog_q <= wdog_q + WW'(1);
        end
    end

    assign wdog_hit = (wdog_q == WW'(WDOG_CYCLES - 1)) && !at_end;
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            rr_q           <= GW'(NUM_REQ - 1);
            grant_q        <= '0;
            x0_q           <= '0;
            y0_q           <= '0;
            x1_q           <= '0;
            y1_q           <= '0;
            color_q        <= 1'b0;
            busy_q         <= 1'b0;
            drawer_reset_q <= 1'b1;
            pix_valid_q    <= 1'b0;
            err_q          <= 1'b0;
            ack_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q <= win_d;
                        x0_q    <= req_x0[win_d*CW +: CW];
                        y0_q    <= req_y0[win_d*CW +: CW];
                        x1_q    <= req_x1[win_d*CW +: CW];
                        y1_q    <= req_y1[win_d*CW +: CW];
                        color_q <= req_color[win_d];
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    drawer_reset_q <= 1'b0;
                    pix_valid_q    <= 1'b1;
                    state_q        <= DRAW;
                end
                DRAW: begin
                    if (at_end || wdog_hit) begin
                        pix_valid_q    <= 1'b0;
                        drawer_reset_q <= 1'b1;
                        ack_q          <= NUM_REQ'(1) << grant_q;
                        err_q          <= wdog_hit;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    rr_q    <= grant_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack          = ack_q;
    assign busy         = busy_q;
    assign drawer_reset = drawer_reset_q;
    assign drawer_x0    = x0_q;
    assign drawer_y0    = y0_q;
    assign drawer_x1    = x1_q;
    assign drawer_y1    = y1_q;
    assign pix_x        = drawer_x;
    assign pix_y        = drawer_y;
    assign pix_color    = color_q;
    assign pix_valid    = pix_valid_q;
    assign err          = err_q;

endmodule
